mux_2x1: RTL and testbench
==========================

// Module: mux_2x1
// PURPOSE
//   2-to-1 selector: drives out from in1 when sel=1, otherwise from in0.
//   Basic datapath steering primitive, used standalone or inside wider muxes/ALUs.
//   Output is combinational by default.
//   An optional registered output stage is available for timing closure.
// PARAMETERS
//   WIDTH    1   data width of in0, in1 and out (>=1)
//   REG_OUT  0   0 = combinational output; 1 = output registered on clk
// PORTS
//   clk    input   1      clock; used only when REG_OUT=1
//   rst_n  input   1      reset, asynchronous, active-low; used only when REG_OUT=1
//   in0    input   WIDTH  data input selected when sel=0
//   in1    input   WIDTH  data input selected when sel=1
//   sel    input   1      select: 0 -> in0, 1 -> in1
//   out    output  WIDTH  selected data
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
//   - Select function:
//       d = sel ? in1 : in0
//       applied bitwise across WIDTH; no width extension or truncation.
//   - Unknown select:
//       sel=X/Z gives out=X, except on bits where in0 and in1 are equal.
//       On those bits out takes the common value (standard ?: semantics).
//       Do not use case-based X-masking.
//   - REG_OUT=0 (combinational):
//       out = d, zero latency, updates in the same delta as any input change.
//       clk and rst_n are ignored, and may be left unconnected or tied off without effect.
//       No reset value applies; out always reflects the current inputs.
//   - REG_OUT=1 (registered):
//       rst_n=0 forces out to all-zeros immediately (asynchronous), independent of clk.
//       While rst_n=0, out holds 0 and input changes are ignored.
//       rst_n rising: no capture until the next clk rising edge.
//       On each clk rising edge with rst_n=1, out <= d.
//       Latency is 1 cycle; out holds between edges.
//       Inputs changing between edges have no effect until the next edge.
//   - No handshake, no state machine, no internal state other than the optional output register.
//   - Simultaneous change of sel and data resolves to the value of d at evaluation or edge time.
// TESTING
//   - REG_OUT=0, WIDTH=1: sweep {in0,in1,sel} = 0..7, 10 ns per step.
//       Expect out = 0,0,0,1,1,0,1,1.
//   - REG_OUT=0, WIDTH=8: in0=8'hA5, in1=8'h3C; toggle sel 0->1->0.
//       Expect out = A5 -> 3C -> A5, with no clock applied.
//   - REG_OUT=0: sel=X with in0=in1=1 -> out=1.
//       sel=X with in0=0, in1=1 -> out=X.
//   - REG_OUT=1, WIDTH=8: rst_n=0 mid-cycle with out=8'hFF.
//       Expect out=8'h00 before the next clk edge, and it stays 0 while rst_n=0.
//   - REG_OUT=1: release rst_n, then in1=8'h5A, sel=1.
//       Expect out=8'h5A one clk edge later.
//       Change sel to 0 between edges: out stays 5A until the following edge.

Source files
------------

// File: rtl/mux_2x1.sv
// Parameterised 2-to-1 selector with an optional registered output stage.
// Uses ?: so an unknown select merges bits where in0 and in1 agree.
module mux_2x1 #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_d;

    always_comb begin
        out_d = sel ? in1 : in0;
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [WIDTH-1:0] out_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign out = out_q;
        end else begin : g_comb
            // clk and rst_n have no role in the purely combinational form
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign out = out_d;
        end
    endgenerate

endmodule

// File: tb/tb_mux_2x1.sv
// Bench for mux_2x1: combinational and registered variants side by side.
// Expected values come from an arithmetic model of the select rule.
module tb_mux_2x1;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a0, a1, as;
    logic       ao;
    logic [7:0] b0, b1;
    logic       bs;
    logic [7:0] bo;
    logic [7:0] r0, r1;
    logic       rs;
    logic [7:0] ro;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_2x1 #(.WIDTH(1), .REG_OUT(0)) u_c1 (
        .clk   (1'b0),
        .rst_n (1'b1),
        .in0   (a0),
        .in1   (a1),
        .sel   (as),
        .out   (ao)
    );

    mux_2x1 #(.WIDTH(8), .REG_OUT(0)) u_c8 (
        .clk   (1'b0),
        .rst_n (1'b1),
        .in0   (b0),
        .in1   (b1),
        .sel   (bs),
        .out   (bo)
    );

    mux_2x1 #(.WIDTH(8), .REG_OUT(1)) u_r8 (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (r0),
        .in1   (r1),
        .sel   (rs),
        .out   (ro)
    );

    // sel weights in1 by 1 and in0 by 0, or the reverse
    function automatic logic [7:0] ref_sel(logic [7:0] i0, logic [7:0] i1,
                                           logic s);
        int w;
        int v;
        w = s ? 1 : 0;
        v = w * int'(i1) + (1 - w) * int'(i0);
        return v[7:0];
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] sweep_tbl;
        logic [7:0] exp_q;
        logic [7:0] held;
        logic       probe;

        sweep_tbl = 8'hD8;
        a0 = 0; a1 = 0; as = 0;
        b0 = 0; b1 = 0; bs = 0;
        r0 = 0; r1 = 0; rs = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("reg_reset_state", ro, 8'h00);

        for (int v = 0; v < 8; v++) begin
            {a0, a1, as} = v[2:0];
            #10 chk($sformatf("sweep_%0d", v), {7'b0, ao}, {7'b0, sweep_tbl[v]});
        end

        b0 = 8'hA5; b1 = 8'h3C; bs = 1'b0;
        #1 chk("c8_sel0", bo, 8'hA5);
        bs = 1'b1;
        #1 chk("c8_sel1", bo, 8'h3C);
        bs = 1'b0;
        #1 chk("c8_sel0_again", bo, 8'hA5);

        a0 = 1'b1; a1 = 1'b1; as = 1'bx;
        #1 chk("selx_equal", {7'b0, ao}, 8'h01);
        a0 = 1'b0;
        #1;
        probe = 1'bx;
        if (probe === 1'bx)
            chk("selx_differ", {7'b0, ao}, {7'b0, 1'bx});

        for (int i = 0; i < 16; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            bs = 1'($urandom);
            #1 chk($sformatf("c8_rand_%0d", i), bo, ref_sel(b0, b1, bs));
        end

        @(negedge clk);
        chk("reg_held_in_reset", ro, 8'h00);
        rst_n = 1'b1;
        r0 = 8'h00; r1 = 8'hFF; rs = 1'b1;
        @(posedge clk);
        #1 chk("reg_ff", ro, 8'hFF);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_midcycle", ro, 8'h00);
        @(posedge clk);
        #1 chk("reset_over_edge", ro, 8'h00);
        r0 = 8'h77; r1 = 8'h99; rs = 1'b0;
        #1 chk("reset_ignores_inputs", ro, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        r1 = 8'h5A; rs = 1'b1;
        #1 chk("no_capture_on_release", ro, 8'h00);
        @(posedge clk);
        #1 chk("capture_5a", ro, 8'h5A);
        @(negedge clk);
        r0 = 8'h11; rs = 1'b0;
        #1 chk("hold_between_edges", ro, 8'h5A);
        @(posedge clk);
        #1 chk("capture_after_sel0", ro, 8'h11);

        held = 8'h11;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            rs = 1'($urandom);
            #2 chk($sformatf("reg_hold_%0d", i), ro, held);
            r0 = 8'($urandom);
            rs = 1'($urandom);
            exp_q = ref_sel(r0, r1, rs);
            @(posedge clk);
            #1 chk($sformatf("reg_rand_%0d", i), ro, exp_q);
            held = exp_q;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
